mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive data grants allowed while a fetch is pending.
REQ-002 SHALL have a single clock and a synchronous, active-high reset.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  synchronous reset, active-high.
REQ-005 if_req_i  input  1  fetch request; held with if_addr_i until if_gnt_o.
REQ-006 if_addr_i  input  64  fetch byte address; bits [1:0] are ignored.
REQ-007 if_gnt_o  output  1  fetch request accepted (one-cycle pulse).
REQ-008 if_rvalid_o / if_rdata_o  output  1 / 32  fetch instruction return.
REQ-009 dm_req_i, dm_we_i  input  1, 1  data request and write-enable; held with payload until dm_gnt_o.
REQ-010 dm_addr_i, dm_wdata_i, dm_wstrb_i  input  64, 64, 8  data address, write data and byte strobes.
REQ-011 dm_gnt_o  output  1  data request accepted (one-cycle pulse).
REQ-012 dm_rvalid_o / dm_rdata_o  output  1 / 64  data read return, or write completion.
REQ-013 mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o  output  1, 1, 64, 64, 8  shared memory request.
REQ-014 mem_ready_i, mem_rvalid_i, mem_rdata_i  input  1, 1, 64  memory accept, read-valid and read data.
REQ-015 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL use FSM states IDLE, REQ and RESP, with one transaction outstanding at a time.
REQ-017 In IDLE, SHALL select a requester and assert its gnt combinationally in the same cycle:
- selected payload and owner are registered;
- next state is REQ.
REQ-018 Selection when both requests are high:
- data wins by default;
- fetch wins once the starve counter equals STARVE_LIMIT.
REQ-019 Starve counter (3 bits, saturating):
- increments on a data grant while if_req_i=1;
- clears on a fetch grant, or on a data grant with if_req_i=0.
REQ-020 In REQ, SHALL drive mem_req_o=1 with the registered payload until mem_ready_i=1; all payload outputs SHALL stay stable meanwhile.
REQ-021 Fetch requests SHALL present mem_we_o=0 and mem_wstrb_o=0, with mem_addr_o = {if_addr[63:3], 3'b000}.
REQ-022 On mem_ready_i in REQ:
- a read goes to RESP;
- a write goes to IDLE and pulses dm_rvalid_o in the same cycle, with dm_rdata_o=0.
REQ-023 In RESP, on mem_rvalid_i, SHALL pass the response through combinationally to the owner and return to IDLE:
- fetch gets if_rdata_o = if_addr[2] ? rdata[63:32] : rdata[31:0];
- data gets the full 64 bits.
REQ-024 mem_rvalid_i outside RESP SHALL be ignored.
REQ-025 Minimum read timing: grant at T, mem_req_o at T+1 (ready at T+1), rvalid at T+2, next grant possible at T+3.
REQ-026 A requester that drops req before its grant SHALL NOT be granted; a grant is never issued outside IDLE.

Reset
REQ-027 On rst_i:
- state goes to IDLE and the starve counter to 0;
- all outputs are 0, including every rdata bus and busy_o.
REQ-028 Reset during REQ or RESP SHALL abandon the transaction:
- mem_req_o is 0 in the following cycle;
- no rvalid is delivered for the abandoned transaction.

Structure
REQ-029 The shared package SHALL hold the arbiter state enum, the owner encoding (OWN_IF, OWN_DM), XLEN=64 and the default STARVE_LIMIT.
REQ-030 Selection logic plus the starve counter SHALL be one sub-module, mem_arb_sel; the FSM and payload registers remain in mem_arbiter.

Verification
REQ-031 Fetch-only read: if_req_i=1, if_addr_i=0x1004, mem_rdata_i=0xAAAA_BBBB_CCCC_DDDD with one-cycle ready and rvalid.
- Expect if_gnt_o at T and mem_addr_o=0x1000 at T+1.
- Expect if_rvalid_o with if_rdata_o=0xAAAABBBB at T+2.
REQ-032 Simultaneous requests: if_req_i and dm_req_i high in the same IDLE cycle.
- Expect dm_gnt_o first, then if_gnt_o after that transaction completes.
REQ-033 Starvation: dm_req_i held high continuously, if_req_i held high.
- Expect exactly 4 data grants, then 1 fetch grant, then the counter at 0.
REQ-034 Write: dm_we_i=1, dm_wstrb_i=0x0F, mem_ready_i delayed 3 cycles.
- Expect mem_req_o held 3 cycles with stable payload.
- Expect a dm_rvalid_o pulse on the ready cycle and a return to IDLE.
REQ-035 Reset in RESP: rst_i asserted, then a late mem_rvalid_i.
- Expect no if_rvalid_o or dm_rvalid_o, busy_o=0 and all outputs 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port (fetch/data) memory arbiter.
package mem_arbiter_pkg;

   localparam int XLEN                 = 64;
   localparam int DEFAULT_STARVE_LIMIT = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arb_sel.sv
// Requester selection: data has priority unless the fetch port has been
// passed over STARVE_LIMIT times in a row.
module mem_arb_sel #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic       if_req_i,
   input  logic       dm_req_i,
   output logic       if_gnt_o,
   output logic       dm_gnt_o,
   output logic [2:0] starve_cnt_o
);

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   logic [2:0] starve_cnt;
   logic       fetch_wins;

   assign fetch_wins   = !dm_req_i || (starve_cnt == LIMIT);
   assign if_gnt_o     = en_i && if_req_i && fetch_wins;
   assign dm_gnt_o     = en_i && dm_req_i && !if_gnt_o;
   assign starve_cnt_o = starve_cnt;

   // Counts data grants that bypassed a waiting fetch; saturates at 7.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         starve_cnt <= 3'd0;
      end else if (if_gnt_o) begin
         starve_cnt <= 3'd0;
      end else if (dm_gnt_o) begin
         if (!if_req_i)
            starve_cnt <= 3'd0;
         else if (starve_cnt != 3'd7)
            starve_cnt <= starve_cnt + 3'd1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port, one
// transaction outstanding at a time (IDLE -> REQ -> RESP/IDLE).
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            if_req_i,
   input  logic [XLEN-1:0] if_addr_i,
   output logic            if_gnt_o,
   output logic            if_rvalid_o,
   output logic [31:0]     if_rdata_o,
   input  logic            dm_req_i,
   input  logic            dm_we_i,
   input  logic [XLEN-1:0] dm_addr_i,
   input  logic [XLEN-1:0] dm_wdata_i,
   input  logic [7:0]      dm_wstrb_i,
   output logic            dm_gnt_o,
   output logic            dm_rvalid_o,
   output logic [XLEN-1:0] dm_rdata_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [XLEN-1:0] mem_wdata_o,
   output logic [7:0]      mem_wstrb_o,
   input  logic            mem_ready_i,
   input  logic            mem_rvalid_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   output logic            busy_o,
   output logic [1:0]      dbg_state_o,
   output logic [2:0]      dbg_starve_o
);

   // Handshakes: a requester holds req+payload until its gnt pulse; the
   // memory request is held until mem_ready_i; read data is accepted on
   // mem_rvalid_i in RESP only, and a write completes on its ready cycle.

   arb_state_t      state;
   owner_t          owner;
   logic            we_q;
   logic            half_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [7:0]      wstrb_q;

   logic            sel_en;
   logic            if_gnt;
   logic            dm_gnt;
   logic [2:0]      starve_cnt;
   logic            req_phase;
   logic            resp_fire;
   logic            wr_done;
   logic            unused_addr_bits;

   assign unused_addr_bits = ^if_addr_i[1:0];
   assign sel_en = (state == ST_IDLE) && !rst_i;

   mem_arb_sel #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_sel (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .en_i        (sel_en),
      .if_req_i    (if_req_i),
      .dm_req_i    (dm_req_i),
      .if_gnt_o    (if_gnt),
      .dm_gnt_o    (dm_gnt),
      .starve_cnt_o(starve_cnt)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= ST_IDLE;
         owner   <= OWN_IF;
         we_q    <= 1'b0;
         half_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (if_gnt) begin
                  owner   <= OWN_IF;
                  we_q    <= 1'b0;
                  half_q  <= if_addr_i[2];
                  addr_q  <= {if_addr_i[XLEN-1:3], 3'b000};
                  wdata_q <= '0;
                  wstrb_q <= '0;
                  state   <= ST_REQ;
               end else if (dm_gnt) begin
                  owner   <= OWN_DM;
                  we_q    <= dm_we_i;
                  half_q  <= 1'b0;
                  addr_q  <= dm_addr_i;
                  wdata_q <= dm_wdata_i;
                  wstrb_q <= dm_wstrb_i;
                  state   <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (mem_ready_i)
                  state <= we_q ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
               if (mem_rvalid_i)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Every output is forced low while reset is asserted.
   assign req_phase = !rst_i && (state == ST_REQ);
   assign resp_fire = !rst_i && (state == ST_RESP) && mem_rvalid_i;
   assign wr_done   = req_phase && mem_ready_i && we_q;

   assign if_gnt_o    = if_gnt;
   assign dm_gnt_o    = dm_gnt;

   assign mem_req_o   = req_phase;
   assign mem_we_o    = req_phase && we_q;
   assign mem_addr_o  = req_phase ? addr_q  : '0;
   assign mem_wdata_o = req_phase ? wdata_q : '0;
   assign mem_wstrb_o = req_phase ? wstrb_q : '0;

   assign if_rvalid_o = resp_fire && (owner == OWN_IF);
   assign if_rdata_o  = !if_rvalid_o ? 32'd0 :
                        half_q ? mem_rdata_i[63:32] : mem_rdata_i[31:0];

   assign dm_rvalid_o = (resp_fire && (owner == OWN_DM)) || wr_done;
   assign dm_rdata_o  = (resp_fire && (owner == OWN_DM)) ? mem_rdata_i : '0;

   assign busy_o       = !rst_i && (state != ST_IDLE);
   assign dbg_state_o  = rst_i ? 2'd0 : state;
   assign dbg_starve_o = rst_i ? 3'd0 : starve_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner-case sequences
// and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_gnt, if_rvalid;
   logic [63:0] if_addr;
   logic [31:0] if_rdata;
   logic        dm_req, dm_we, dm_gnt, dm_rvalid;
   logic [63:0] dm_addr, dm_wdata, dm_rdata;
   logic [7:0]  dm_wstrb;
   logic        mem_req, mem_we, mem_ready, mem_rvalid;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  mem_wstrb;
   logic        busy;
   logic [1:0]  dbg_state;
   logic [2:0]  dbg_starve;

   mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
      .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
      .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr),
      .dm_wdata_i(dm_wdata), .dm_wstrb_i(dm_wstrb), .dm_gnt_o(dm_gnt),
      .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
      .mem_ready_i(mem_ready), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
      .busy_o(busy), .dbg_state_o(dbg_state), .dbg_starve_o(dbg_starve)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      if_req = 0; if_addr = '0;
      dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
      mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
   endtask

   task automatic do_reset;
      idle_inputs();
      rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        if_req;
      logic        dm_req;
      logic        we;
      logic [63:0] if_addr;
      logic [63:0] dm_addr;
      logic [63:0] rdata;
      logic        exp_if_gnt;
      logic        exp_dm_gnt;
      logic [63:0] exp_addr;
      logic [63:0] exp_rdata;
   } vec_t;

   vec_t vecs[8];

   // random-run model state
   logic        m_if_pend, m_dm_pend, m_dm_we;
   logic [63:0] m_if_addr, m_dm_addr, m_dm_wdata;
   logic [7:0]  m_dm_wstrb;
   int          m_phase;     // 0 free, 1 memory request open, 2 awaiting read data
   int          m_starve;
   logic        c_if, c_we, c_half;
   logic [63:0] c_addr, c_wdata;
   logic [7:0]  c_wstrb;
   logic        grant_seq[$];

   initial begin
      vecs[0] = '{1, 0, 0, 64'h1004, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD, 1, 0, 64'h1000, 64'hAAAA_BBBB};
      vecs[1] = '{1, 0, 0, 64'h1000, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD, 1, 0, 64'h1000, 64'hCCCC_DDDD};
      vecs[2] = '{1, 0, 0, 64'hFFFF_0000_0000_100F, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 0,
                  64'hFFFF_0000_0000_1008, 64'h0123_4567};
      vecs[3] = '{0, 1, 0, 64'h0, 64'h2000, 64'h0123_4567_89AB_CDEF, 0, 1, 64'h2000, 64'h0123_4567_89AB_CDEF};
      vecs[4] = '{1, 1, 0, 64'h1004, 64'h2008, 64'hDEAD_BEEF_CAFE_F00D, 0, 1, 64'h2008, 64'hDEAD_BEEF_CAFE_F00D};
      vecs[5] = '{0, 1, 1, 64'h0, 64'h4000, 64'h0, 0, 1, 64'h4000, 64'h0};
      vecs[6] = '{0, 0, 0, 64'h1234, 64'h5678, 64'h0, 0, 0, 64'h0, 64'h0};
      vecs[7] = '{1, 1, 1, 64'h1004, 64'h5000, 64'h0, 0, 1, 64'h5000, 64'h0};

      // ---- reset: every output low even with all inputs active ----
      idle_inputs();
      rst = 1; if_req = 1; dm_req = 1; mem_ready = 1; mem_rvalid = 1; mem_rdata = '1;
      tick();
      tick();
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_dm_gnt", dm_gnt, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_dm_rvalid", dm_rvalid, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_dm_rdata", dm_rdata, 0);
      chk("rst_starve", dbg_starve, 0);

      // ---- table-driven single transactions, minimum timing ----
      for (int i = 0; i < 8; i++) begin
         do_reset();
         if_req   = vecs[i].if_req;
         dm_req   = vecs[i].dm_req;
         dm_we    = vecs[i].we;
         if_addr  = vecs[i].if_addr;
         dm_addr  = vecs[i].dm_addr;
         dm_wdata = 64'h1111_2222_3333_4444 + 64'(i);
         dm_wstrb = vecs[i].we ? 8'h0F : 8'h00;
         #1;
         chk($sformatf("v%0d_if_gnt", i), if_gnt, vecs[i].exp_if_gnt);
         chk($sformatf("v%0d_dm_gnt", i), dm_gnt, vecs[i].exp_dm_gnt);
         tick();
         if_req = 0; dm_req = 0;
         if (!vecs[i].exp_if_gnt && !vecs[i].exp_dm_gnt) begin
            #1 chk($sformatf("v%0d_busy_none", i), busy, 0);
            continue;
         end
         mem_ready = 1;
         #1;
         chk($sformatf("v%0d_mem_req", i), mem_req, 1);
         chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
         chk($sformatf("v%0d_mem_we", i), mem_we, vecs[i].we && vecs[i].exp_dm_gnt);
         chk($sformatf("v%0d_mem_wstrb", i), mem_wstrb,
             (vecs[i].we && vecs[i].exp_dm_gnt) ? 8'h0F : 8'h00);
         if (vecs[i].we) begin
            chk($sformatf("v%0d_wr_rvalid", i), dm_rvalid, 1);
            chk($sformatf("v%0d_wr_rdata", i), dm_rdata, 0);
            tick();
            mem_ready = 0;
            #1 chk($sformatf("v%0d_wr_idle", i), busy, 0);
         end else begin
            chk($sformatf("v%0d_early_rvalid", i), dm_rvalid | if_rvalid, 0);
            tick();
            mem_ready = 0; mem_rvalid = 1; mem_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_if_rvalid", i), if_rvalid, vecs[i].exp_if_gnt);
            chk($sformatf("v%0d_dm_rvalid", i), dm_rvalid, vecs[i].exp_dm_gnt);
            chk($sformatf("v%0d_if_rdata", i), {32'd0, if_rdata},
                vecs[i].exp_if_gnt ? vecs[i].exp_rdata : 64'd0);
            chk($sformatf("v%0d_dm_rdata", i), dm_rdata,
                vecs[i].exp_dm_gnt ? vecs[i].exp_rdata : 64'd0);
            tick();
            mem_rvalid = 0;
            #1 chk($sformatf("v%0d_rd_idle", i), busy, 0);
         end
      end

      // ---- simultaneous then follow-up: data first, fetch after completion ----
      do_reset();
      if_req = 1; if_addr = 64'h1004; dm_req = 1; dm_addr = 64'h2000;
      #1 chk("both_dm_first", dm_gnt, 1);
      tick();
      dm_req = 0; mem_ready = 1;
      #1 chk("both_no_if_in_req", if_gnt, 0);
      tick();
      mem_ready = 0; mem_rvalid = 1; mem_rdata = 64'h5555_6666_7777_8888;
      #1 chk("both_no_if_in_resp", if_gnt, 0);
      tick();
      mem_rvalid = 0;
      #1 chk("both_if_second", if_gnt, 1);

      // ---- starvation: both held, expect DM x4 then IF ----
      do_reset();
      grant_seq.delete();
      if_req = 1; if_addr = 64'h1004; dm_req = 1; dm_addr = 64'h2000;
      mem_ready = 1; mem_rvalid = 1; mem_rdata = 64'h0BAD_F00D_0BAD_F00D;
      for (int c = 0; c < 60; c++) begin
         #1;
         if (dm_gnt) grant_seq.push_back(1'b1);
         if (if_gnt) grant_seq.push_back(1'b0);
         if (grant_seq.size() >= 5) break;
         tick();
      end
      chk("starve_grant_count", 64'(grant_seq.size()), 5);
      for (int k = 0; k < 5 && k < grant_seq.size(); k++)
         chk($sformatf("starve_grant%0d_is_dm", k), grant_seq[k], (k < 4) ? 1 : 0);
      tick();
      #1 chk("starve_cnt_cleared", dbg_starve, 0);
      idle_inputs();

      // ---- write with ready after 3 request cycles, stable payload ----
      do_reset();
      dm_req = 1; dm_we = 1; dm_addr = 64'h3008;
      dm_wdata = 64'h1122_3344_5566_7788; dm_wstrb = 8'h0F;
      #1 chk("wr_gnt", dm_gnt, 1);
      tick();
      dm_req = 0; dm_we = 0; dm_addr = 64'hFFFF; dm_wdata = '1; dm_wstrb = 8'hF0;
      for (int c = 0; c < 3; c++) begin
         mem_ready = (c == 2);
         #1;
         chk($sformatf("wr_c%0d_mem_req", c), mem_req, 1);
         chk($sformatf("wr_c%0d_addr", c), mem_addr, 64'h3008);
         chk($sformatf("wr_c%0d_wdata", c), mem_wdata, 64'h1122_3344_5566_7788);
         chk($sformatf("wr_c%0d_wstrb", c), mem_wstrb, 8'h0F);
         chk($sformatf("wr_c%0d_we", c), mem_we, 1);
         chk($sformatf("wr_c%0d_rvalid", c), dm_rvalid, (c == 2) ? 1 : 0);
         tick();
      end
      mem_ready = 0;
      #1;
      chk("wr_done_idle", busy, 0);
      chk("wr_done_mem_req", mem_req, 0);

      // ---- drop before grant: no grant while busy, none after withdrawal ----
      do_reset();
      dm_req = 1; dm_addr = 64'h2000;
      tick();
      dm_req = 0; if_req = 1; if_addr = 64'h1000; mem_ready = 1;
      #1 chk("drop_no_gnt_busy", if_gnt, 0);
      tick();
      if_req = 0; mem_ready = 0; mem_rvalid = 1;
      tick();
      mem_rvalid = 0;
      #1 chk("drop_no_if_gnt", if_gnt, 0);
      chk("drop_no_dm_gnt", dm_gnt, 0);
      tick();
      #1 chk("drop_idle", busy, 0);

      // ---- reset during REQ ----
      do_reset();
      dm_req = 1; dm_addr = 64'h2000;
      tick();
      dm_req = 0;
      #1 chk("rstreq_mem_req_before", mem_req, 1);
      rst = 1;
      tick();
      rst = 0; mem_ready = 1;
      #1;
      chk("rstreq_mem_req_after", mem_req, 0);
      chk("rstreq_busy", busy, 0);
      tick();
      mem_ready = 0;

      // ---- reset during RESP, then a late rvalid ----
      do_reset();
      if_req = 1; if_addr = 64'h1004;
      tick();
      if_req = 0; mem_ready = 1;
      tick();
      mem_ready = 0; rst = 1;
      #1 chk("rstresp_if_rvalid_in_rst", if_rvalid, 0);
      tick();
      rst = 0; mem_rvalid = 1; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
      #1;
      chk("rstresp_if_rvalid", if_rvalid, 0);
      chk("rstresp_dm_rvalid", dm_rvalid, 0);
      chk("rstresp_busy", busy, 0);
      chk("rstresp_mem_req", mem_req, 0);
      chk("rstresp_if_rdata", if_rdata, 0);
      chk("rstresp_dm_rdata", dm_rdata, 0);
      tick();
      mem_rvalid = 0;

      // ---- randomized run against the transaction model ----
      do_reset();
      m_if_pend = 0; m_dm_pend = 0; m_phase = 0; m_starve = 0;
      m_if_addr = '0; m_dm_addr = '0; m_dm_wdata = '0; m_dm_wstrb = '0; m_dm_we = 0;
      c_if = 0; c_we = 0; c_half = 0; c_addr = '0; c_wdata = '0; c_wstrb = '0;
      exp_q.delete();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic e_if_gnt, e_dm_gnt, e_resp, e_wr;
         if (m_if_pend && $urandom_range(0, 19) == 0) m_if_pend = 0;
         if (m_dm_pend && $urandom_range(0, 19) == 0) m_dm_pend = 0;
         if (!m_if_pend && $urandom_range(0, 2) == 0) begin
            m_if_pend = 1;
            m_if_addr = {$urandom, $urandom};
         end
         if (!m_dm_pend && $urandom_range(0, 2) == 0) begin
            m_dm_pend  = 1;
            m_dm_we    = 1'($urandom_range(0, 1));
            m_dm_addr  = {$urandom, $urandom};
            m_dm_wdata = {$urandom, $urandom};
            m_dm_wstrb = 8'($urandom);
         end
         if_req = m_if_pend; if_addr = m_if_addr;
         dm_req = m_dm_pend; dm_we = m_dm_we; dm_addr = m_dm_addr;
         dm_wdata = m_dm_wdata; dm_wstrb = m_dm_wstrb;
         mem_ready  = ($urandom_range(0, 2) != 0);
         mem_rvalid = 1'($urandom_range(0, 1));
         mem_rdata  = {$urandom, $urandom};
         #1;
         e_if_gnt = (m_phase == 0) && m_if_pend && (!m_dm_pend || m_starve == LIMIT);
         e_dm_gnt = (m_phase == 0) && m_dm_pend && !e_if_gnt;
         e_resp   = (m_phase == 2) && mem_rvalid;
         e_wr     = (m_phase == 1) && mem_ready && c_we;
         chk("rnd_if_gnt", if_gnt, e_if_gnt);
         chk("rnd_dm_gnt", dm_gnt, e_dm_gnt);
         chk("rnd_mem_req", mem_req, m_phase == 1);
         chk("rnd_busy", busy, m_phase != 0);
         if (m_phase == 1) begin
            chk("rnd_mem_addr", mem_addr, c_addr);
            chk("rnd_mem_we", mem_we, c_we);
            chk("rnd_mem_wdata", mem_wdata, c_wdata);
            chk("rnd_mem_wstrb", mem_wstrb, c_wstrb);
            if (mem_ready) begin
               if (exp_q.size() == 0) chk("rnd_sb_empty", 1, 0);
               else chk("rnd_sb_addr", mem_addr, exp_q.pop_front());
            end
         end
         chk("rnd_if_rvalid", if_rvalid, e_resp && c_if);
         chk("rnd_dm_rvalid", dm_rvalid, (e_resp && !c_if) || e_wr);
         chk("rnd_if_rdata", {32'd0, if_rdata},
             (e_resp && c_if) ? (c_half ? {32'd0, mem_rdata[63:32]} : {32'd0, mem_rdata[31:0]}) : 64'd0);
         chk("rnd_dm_rdata", dm_rdata, (e_resp && !c_if) ? mem_rdata : 64'd0);
         if (e_if_gnt) begin
            c_if = 1; c_we = 0; c_half = m_if_addr[2];
            c_addr = {m_if_addr[63:3], 3'b000}; c_wdata = '0; c_wstrb = '0;
            m_starve = 0; m_if_pend = 0; m_phase = 1;
            exp_q.push_back(c_addr);
         end else if (e_dm_gnt) begin
            c_if = 0; c_we = m_dm_we; c_half = 0;
            c_addr = m_dm_addr; c_wdata = m_dm_wdata; c_wstrb = m_dm_wstrb;
            m_starve = m_if_pend ? ((m_starve < 7) ? m_starve + 1 : 7) : 0;
            m_dm_pend = 0; m_phase = 1;
            exp_q.push_back(c_addr);
         end else if (m_phase == 1 && mem_ready) begin
            m_phase = c_we ? 0 : 2;
         end else if (m_phase == 2 && mem_rvalid) begin
            m_phase = 0;
         end
         tick();
      end
      idle_inputs();

      // ---- final report ----
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
